instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Fetch stage sitting directly downstream of the `programCounter` register and upstream of decode. It reads the current `pc`, issues one instruction-memory request at a time, and drives the PC register's `enable`/`adr` inputs to advance (pc+4) or redirect. It also loads the reset vector after reset, because the PC register itself has no reset. Fetched words are presented to decode with their PC over a valid/ready handshake.

## Interface
- `WIDTH`, 32: address/instruction width.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `pc` in WIDTH: current PC from `programCounter`.
- `pc_enable` out 1: load strobe to `programCounter.enable`.
- `next_adr` out WIDTH: value to `programCounter.adr`.
- `redirect_valid` in 1: branch/jump redirect this cycle.
- `redirect_adr` in WIDTH: redirect target.
- `imem_req_valid` out 1: instruction-memory read request.
- `imem_req_adr` out WIDTH: request address.
- `imem_req_ready` in 1: memory accepts request.
- `imem_rsp_valid` in 1: read data valid (one response per accepted request, in order).
- `imem_rsp_data` in WIDTH: read data.
- `inst_valid` out 1: instruction available to decode.
- `inst_data` out WIDTH: instruction word.
- `inst_pc` out WIDTH: PC of `inst_data`.
- `inst_ready` in 1: decode accepts instruction.

## Operation
- States: BOOT, REQ, WAIT, HOLD, DROP. Reset state is BOOT.
- BOOT (one cycle): `pc_enable`=1, `next_adr`=RESET_PC → REQ.
- REQ: `imem_req_valid`=1, `imem_req_adr`=`pc`. On `imem_req_ready`:
  - `pc_enable`=1, `next_adr`=`pc`+4 (mod 2^WIDTH, wraps silently).
  - Latch `pc` into `req_pc`, go to WAIT.
- WAIT: on `imem_rsp_valid`, capture `imem_rsp_data` into `inst_data` and `req_pc` into `inst_pc` → HOLD.
- HOLD: `inst_valid`=1; outputs stable until `inst_ready`, then → REQ.
- Redirect (`redirect_valid`=1) has priority in every state except BOOT, where it is ignored:
  - `pc_enable`=1, `next_adr`=`redirect_adr` with bits [1:0] forced to 0; this overrides the pc+4 update.
  - REQ: `imem_req_valid` forced 0 that cycle; stay in REQ.
  - WAIT without `imem_rsp_valid` → DROP. WAIT with `imem_rsp_valid` the same cycle → response discarded, go to REQ.
  - HOLD: buffered instruction discarded (even if `inst_ready`=1), `inst_valid` low next cycle → REQ.
  - DROP: stay in DROP.
- DROP: discard the next `imem_rsp_valid` → REQ. `inst_valid` stays 0.
- Only one request is outstanding at any time. `imem_req_valid` is 0 in all states other than REQ.

## Timing
- Reset values: state=BOOT, `inst_valid`=0, `inst_data`=0, `inst_pc`=0, `req_pc`=0.
- While `rst_n`=0: `pc_enable`=0, `imem_req_valid`=0. Reset mid-transaction abandons it; a late response arriving after reset is ignored until the next request.
- `pc_enable`, `next_adr`, `imem_req_*` are combinational from state, `pc`, and inputs.
- `inst_*` are registered.
- With zero-wait memory (ready=1, response the cycle after acceptance):
  - Request accepted at cycle N, `inst_valid` high from N+2.
  - Throughput is one instruction per 3 cycles with `inst_ready` tied high.
- `pc` reflects `next_adr` one cycle after `pc_enable`.

## Structure
- Shared package/header `fetch_defs`: state encodings (3-bit), `INSTR_BYTES`=4, `RESET_PC` default.
- Single flat module. The pc+4 adder is inline; no sub-module is warranted.
- The bench instantiates `programCounter` alongside this block to close the PC loop.

## Test plan
- Reset release, ready=1, memory returns `pc`^32'hA5A5_A5A5 → first `inst_pc`=0, then 4, 8; `inst_data` matches; 3-cycle cadence.
- `inst_ready`=0 for 5 cycles in HOLD → `inst_data`/`inst_pc` stable, no new request, `pc` unchanged.
- Redirect to 32'h100 during WAIT → in-flight response dropped, next `inst_pc`=32'h100, no instruction with old pc+4.
- Redirect in HOLD with `inst_ready`=1 the same cycle → instruction not consumed (`inst_valid` low next cycle), fetch resumes at target. Redirect to 32'h103 → fetch at 32'h100.
- `pc`=32'hFFFF_FFFC accepted → `next_adr`=0 (wrap); `imem_req_ready` held low 4 cycles → `imem_req_valid` stays high, `pc` held.
- `rst_n` asserted in WAIT → outputs at reset values immediately; after release a BOOT cycle reloads RESET_PC.

Source files
------------

// File: rtl/fetch_defs.sv
// Shared fetch-stage definitions: FSM encodings and fetch constants.
package fetch_defs;

  typedef enum logic [2:0] {
    ST_BOOT = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_HOLD = 3'd3,
    ST_DROP = 3'd4
  } state_t;

  localparam int          INSTR_BYTES      = 4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/instruction_fetch.sv
// Fetch stage: one outstanding imem read, drives the PC register,
// hands fetched words to decode over valid/ready.
module instruction_fetch
  import fetch_defs::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEFAULT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pc,
  output logic             pc_enable,
  output logic [WIDTH-1:0] next_adr,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_adr,
  output logic             imem_req_valid,
  output logic [WIDTH-1:0] imem_req_adr,
  input  logic             imem_req_ready,
  input  logic             imem_rsp_valid,
  input  logic [WIDTH-1:0] imem_rsp_data,
  output logic             inst_valid,
  output logic [WIDTH-1:0] inst_data,
  output logic [WIDTH-1:0] inst_pc,
  input  logic             inst_ready
);

  state_t           state;
  state_t           state_n;
  logic [WIDTH-1:0] req_pc;
  logic [WIDTH-1:0] target;
  logic             en;
  logic             req_v;
  logic             accept;
  logic             capture;
  logic             clear;

  assign target = {redirect_adr[WIDTH-1:2], 2'b00};

  always_comb begin
    state_n  = state;
    en       = 1'b0;
    req_v    = 1'b0;
    accept   = 1'b0;
    capture  = 1'b0;
    clear    = 1'b0;
    next_adr = pc + WIDTH'(INSTR_BYTES);
    unique case (state)
      ST_BOOT: begin
        en       = 1'b1;
        next_adr = RESET_PC;
        state_n  = ST_REQ;
      end
      ST_REQ: begin
        if (redirect_valid) begin
          en       = 1'b1;
          next_adr = target;
        end else begin
          req_v = 1'b1;
          if (imem_req_ready) begin
            en      = 1'b1;
            accept  = 1'b1;
            state_n = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (redirect_valid) begin
          en       = 1'b1;
          next_adr = target;
          state_n  = imem_rsp_valid ? ST_REQ : ST_DROP;
        end else if (imem_rsp_valid) begin
          capture = 1'b1;
          state_n = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // A redirect kills the buffered word even if decode takes it.
        if (redirect_valid) begin
          en       = 1'b1;
          next_adr = target;
          clear    = 1'b1;
          state_n  = ST_REQ;
        end else if (inst_ready) begin
          clear   = 1'b1;
          state_n = ST_REQ;
        end
      end
      ST_DROP: begin
        if (redirect_valid) begin
          en       = 1'b1;
          next_adr = target;
        end else if (imem_rsp_valid) begin
          state_n = ST_REQ;
        end
      end
      default: state_n = ST_BOOT;
    endcase
  end

  // BOOT is the reset state, so gate the strobes while reset is held.
  assign pc_enable      = en & rst_n;
  assign imem_req_valid = req_v & rst_n;
  assign imem_req_adr   = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_BOOT;
      req_pc     <= '0;
      inst_valid <= 1'b0;
      inst_data  <= '0;
      inst_pc    <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        req_pc <= pc;
      end
      if (capture) begin
        inst_valid <= 1'b1;
        inst_data  <= imem_rsp_data;
        inst_pc    <= req_pc;
      end else if (clear) begin
        inst_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a PC register and a
// variable-latency instruction memory closing the loop.
module tb_instruction_fetch;

  localparam logic [31:0] KEY = 32'hA5A5_A5A5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc = 32'hDEAD_BEEF;
  logic        pc_enable;
  logic [31:0] next_adr;
  logic        redirect_valid;
  logic [31:0] redirect_adr;
  logic        imem_req_valid;
  logic [31:0] imem_req_adr;
  logic        imem_req_ready;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready;

  int n_tests = 0;
  int n_fail  = 0;
  int lat     = 1;

  logic        mem_busy = 1'b0;
  int          mem_cnt  = 0;
  logic [31:0] mem_adr  = '0;

  always #5 clk = ~clk;

  instruction_fetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc             (pc),
    .pc_enable      (pc_enable),
    .next_adr       (next_adr),
    .redirect_valid (redirect_valid),
    .redirect_adr   (redirect_adr),
    .imem_req_valid (imem_req_valid),
    .imem_req_adr   (imem_req_adr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready)
  );

  // PC register: no reset, loads on enable.
  always @(posedge clk) begin
    if (pc_enable) pc <= next_adr;
  end

  // Memory: responds lat cycles after acceptance, data = adr ^ KEY.
  always @(posedge clk) begin
    imem_rsp_valid <= 1'b0;
    if (mem_busy) begin
      if (mem_cnt <= 1) begin
        imem_rsp_valid <= 1'b1;
        imem_rsp_data  <= mem_adr ^ KEY;
        mem_busy       <= 1'b0;
      end else begin
        mem_cnt <= mem_cnt - 1;
      end
    end
    if (imem_req_valid && imem_req_ready) begin
      if (lat <= 1) begin
        imem_rsp_valid <= 1'b1;
        imem_rsp_data  <= imem_req_adr ^ KEY;
      end else begin
        mem_busy <= 1'b1;
        mem_cnt  <= lat - 1;
        mem_adr  <= imem_req_adr;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until inst_valid (bounded), then checks the word and latency.
  task automatic expect_inst(input string tag, input logic [31:0] epc,
                             input int ecyc);
    int n;
    step();
    n = 1;
    while (!inst_valid && n < 50) begin
      step();
      n++;
    end
    check({tag, "_valid"}, 32'(inst_valid), 32'd1);
    check({tag, "_pc"}, inst_pc, epc);
    check({tag, "_data"}, inst_data, epc ^ KEY);
    if (ecyc >= 0) check({tag, "_cyc"}, 32'(n), 32'(ecyc));
  endtask

  initial begin
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_adr   = '0;
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;
    step();
    step();
    check("rst_pc_en", 32'(pc_enable), 32'd0);
    check("rst_req_v", 32'(imem_req_valid), 32'd0);
    check("rst_ivalid", 32'(inst_valid), 32'd0);
    check("rst_idata", inst_data, 32'd0);
    check("rst_ipc", inst_pc, 32'd0);

    rst_n = 1'b1;
    #1;
    check("boot_en", 32'(pc_enable), 32'd1);
    check("boot_adr", next_adr, 32'h0);
    expect_inst("i0", 32'h0, 3);
    expect_inst("i1", 32'h4, 3);
    expect_inst("i2", 32'h8, 3);

    expect_inst("i3", 32'hC, 3);
    inst_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_v", 32'(inst_valid), 32'd1);
      check("stall_pc", inst_pc, 32'hC);
      check("stall_req", 32'(imem_req_valid), 32'd0);
      check("stall_pcreg", pc, 32'h10);
    end
    inst_ready = 1'b1;
    step();
    check("unstall_v", 32'(inst_valid), 32'd0);
    check("unstall_adr", imem_req_adr, 32'h10);

    lat = 3;
    step();
    redirect_valid = 1'b1;
    redirect_adr   = 32'h100;
    #1;
    check("wr_en", 32'(pc_enable), 32'd1);
    check("wr_adr", next_adr, 32'h100);
    step();
    redirect_valid = 1'b0;
    lat            = 1;
    check("drop_req", 32'(imem_req_valid), 32'd0);
    check("drop_v", 32'(inst_valid), 32'd0);
    expect_inst("after_drop", 32'h100, -1);

    expect_inst("i104", 32'h104, 3);
    redirect_valid = 1'b1;
    redirect_adr   = 32'h103;
    #1;
    check("hr_adr", next_adr, 32'h100);
    step();
    redirect_valid = 1'b0;
    check("hr_v", 32'(inst_valid), 32'd0);
    check("hr_req", imem_req_adr, 32'h100);
    expect_inst("hr_inst", 32'h100, 2);

    step();
    redirect_valid = 1'b1;
    redirect_adr   = 32'hFFFF_FFFD;
    imem_req_ready = 1'b0;
    #1;
    check("rr_req", 32'(imem_req_valid), 32'd0);
    step();
    redirect_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("nrdy_req", 32'(imem_req_valid), 32'd1);
      check("nrdy_en", 32'(pc_enable), 32'd0);
      check("nrdy_pc", pc, 32'hFFFF_FFFC);
      step();
    end
    imem_req_ready = 1'b1;
    #1;
    check("wrap_adr", next_adr, 32'h0);
    expect_inst("wrap", 32'hFFFF_FFFC, 2);
    expect_inst("post_wrap", 32'h0, 3);

    lat = 3;
    step();
    step();
    rst_n = 1'b0;
    #1;
    check("mrst_en", 32'(pc_enable), 32'd0);
    check("mrst_req", 32'(imem_req_valid), 32'd0);
    check("mrst_idata", inst_data, 32'd0);
    check("mrst_ipc", inst_pc, 32'd0);
    step();
    rst_n = 1'b1;
    #1;
    check("reboot_en", 32'(pc_enable), 32'd1);
    check("reboot_adr", next_adr, 32'h0);
    lat = 1;
    expect_inst("reboot", 32'h0, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
